bht_sat_ctr_table: RTL and testbench
====================================

# bht_sat_ctr_table

Parametrised branch history table for the dynamic branch predictor. It holds 2^AWIDTH saturating counters and provides NREAD registered prediction read ports plus one read-modify-write update port with internal forwarding. After every reset it clears itself with an initialisation sweep, so it needs no memory-init file. It sits between the fetch-stage predictor lookup and the execute-stage branch-resolution feedback.

## Interface
- AWIDTH, 10, index width; DEPTH = 2**AWIDTH entries
- CWIDTH, 2, counter width (≥2); prediction = counter MSB
- NREAD, 2, number of independent prediction read ports (≥1)
- INIT_VAL, 1, counter value written by the init sweep (weakly not-taken for CWIDTH=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NREAD*AWIDTH  read indices; port i at [i*AWIDTH +: AWIDTH]
- rd_ctr  out  NREAD*CWIDTH  registered counter per port
- rd_taken  out  NREAD  registered prediction (MSB of rd_ctr slice)
- upd_valid  in  1  branch-resolution update strobe
- upd_addr  in  AWIDTH  index to update
- upd_taken  in  1  resolved outcome; 1 = increment, 0 = decrement
- ready  out  1  high once the init sweep is complete
- upd_drop  out  1  registered pulse: an update was discarded because ready was low

## Operation
- FSM states: INIT and RUN. Reset forces INIT, clears the sweep pointer to 0, and clears the stage-1 valid bit.
- INIT state:
  - Write INIT_VAL to mem[ptr] each cycle and increment ptr.
  - At ptr = DEPTH-1, write the final entry, set ready, and move to RUN.
- RUN state: ready stays 1 until the next reset.
- Updates while ready=0 are discarded, and upd_drop pulses for one cycle per discarded update.
- While ready=0, every rd_ctr slice reads INIT_VAL, regardless of memory contents.
- Update pipeline, two stages:
  - S0, at the edge where upd_valid=1: capture addr, taken, and old = mem[addr] into the S1 register.
  - S1, the following cycle: compute new = sat(old, taken), and write mem[addr] <= new at the next edge.
- Saturation: increment clamps at 2^CWIDTH-1 and decrement clamps at 0. All arithmetic is CWIDTH-bit unsigned with no wrap.
- Update forwarding: if S1 writes address A at the same edge S0 captures address A, S0 captures S1's new value, not stale memory. Back-to-back updates to one index therefore accumulate correctly at full rate.
- Read ports are write-first. At edge t, rd_ctr slice i = the value being written to rd_addr[i] at edge t if a write hits it, otherwise mem[rd_addr[i]]. This holds for both S1 and INIT writes.
- Ports reading the same index in the same cycle always return identical values.
- Only one memory write occurs per cycle, because INIT and RUN are mutually exclusive.

## Timing
- Read latency is 1 cycle: rd_addr sampled at edge t appears on rd_ctr/rd_taken after edge t.
- Update-to-visible latency is 2 edges. With upd_valid at edge t, the memory write happens at edge t+1, and a read issued at edge t+1 returns the new value.
- Update throughput is 1 per cycle, any address pattern.
- Init takes DEPTH cycles. With the first non-reset edge being e1, ready=1 after edge e1+DEPTH-1.
- Reset values:
  - rd_ctr slices = INIT_VAL
  - rd_taken = INIT_VAL MSB
  - ready = 0
  - upd_drop = 0
  - S1 valid = 0
- Reset mid-operation:
  - A pending S1 write is cancelled and not committed.
  - The sweep restarts at entry 0.
  - All prior counter contents are overwritten before ready rises.
- An update arriving in the cycle ready first rises is accepted.

## Structure
- Package bht_pkg holds:
  - the state enum (ST_INIT, ST_RUN)
  - the default AWIDTH/CWIDTH constants
  - the function sat_next(ctr, taken)
- One sub-module, bht_sat_ctr: combinational CWIDTH-bit saturating counter update, instantiated in S1.
- Memory is a single register array, written on one write port with NREAD read ports. Forwarding and bypass muxes live in the top level.

## Test plan
- Init, AWIDTH=4: release reset and count edges. Required: ready after exactly 16 edges; all 16 indices read 1 on both ports; upd_valid during init gives an upd_drop pulse and leaves the entry at 1.
- Saturation: four taken updates to index 5, spaced 3 cycles apart, read after each. Required: 2, 3, 3, 3. Then four not-taken updates. Required: 2, 1, 0, 0, with rd_taken following the MSB.
- Back-to-back forwarding: consecutive cycles to index 9 with taken, taken, not-taken, from 1. Required final value 2. Consecutive taken×3 to index 9 then index 10. Required: index 9 = 3, index 10 = 2.
- Write-first bypass: read index 9 on port 0 at the same edge S1 writes 9 (1→2). Required: rd_ctr = 2 next cycle. Port 1 reading index 9 in the same cycle also gives 2.
- Reset mid-run: set index 3 to 3, issue an update to index 3, and assert reset one cycle later. Required: ready=0, rd_ctr=INIT_VAL, and after a new sweep index 3 reads 1.
- Parametric: NREAD=4, CWIDTH=3, four different indices per cycle under random updates. Required: matches a reference model cycle-for-cycle, with clamping at 7 and 0.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table.
// sat_next works on a widened counter so any CWIDTH up to SAT_MAXW can share it.
package bht_pkg;

    localparam int BHT_AWIDTH = 10;
    localparam int BHT_CWIDTH = 2;
    localparam int SAT_MAXW   = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    function automatic logic [SAT_MAXW-1:0] sat_next(input logic [SAT_MAXW-1:0] ctr,
                                                     input logic                taken,
                                                     input logic [SAT_MAXW-1:0] ctr_max);
        if (taken) begin
            return (ctr >= ctr_max) ? ctr_max : ctr + SAT_MAXW'(1);
        end
        return (ctr == '0) ? '0 : ctr - SAT_MAXW'(1);
    endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// Combinational CWIDTH-bit saturating up/down counter step.
module bht_sat_ctr
    import bht_pkg::*;
#(
    parameter int CWIDTH = BHT_CWIDTH
) (
    input  logic [CWIDTH-1:0] ctr_i,
    input  logic              taken_i,
    output logic [CWIDTH-1:0] ctr_o
);

    localparam logic [SAT_MAXW-1:0] CTR_MAX = SAT_MAXW'((2 ** CWIDTH) - 1);

    logic [SAT_MAXW-1:0] sat_wide;
    logic                unused_hi;

    assign sat_wide  = sat_next(SAT_MAXW'(ctr_i), taken_i, CTR_MAX);
    assign ctr_o     = sat_wide[CWIDTH-1:0];
    // Upper bits are always zero because the clamp is below 2^CWIDTH.
    assign unused_hi = ^sat_wide;

endmodule

// File: rtl/bht_sat_ctr_table.sv
// Branch history table of saturating counters: NREAD registered write-first read
// ports, one two-stage forwarded update port, and a self-clearing init sweep.
module bht_sat_ctr_table
    import bht_pkg::*;
#(
    parameter int AWIDTH   = BHT_AWIDTH,
    parameter int CWIDTH   = BHT_CWIDTH,
    parameter int NREAD    = 2,
    parameter int INIT_VAL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AWIDTH-1:0] rd_addr,
    output logic [NREAD*CWIDTH-1:0] rd_ctr,
    output logic [NREAD-1:0]        rd_taken,
    input  logic                    upd_valid,
    input  logic [AWIDTH-1:0]       upd_addr,
    input  logic                    upd_taken,
    output logic                    ready,
    output logic                    upd_drop
);

    localparam int                DEPTH    = 2 ** AWIDTH;
    localparam logic [CWIDTH-1:0] INIT_CTR = CWIDTH'(INIT_VAL);
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    logic [CWIDTH-1:0] mem_q [DEPTH];

    bht_state_e        state_q, state_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;
    logic              s1_valid_q;
    logic [AWIDTH-1:0] s1_addr_q;
    logic              s1_taken_q;
    logic [CWIDTH-1:0] s1_old_q, s1_old_d;
    logic [CWIDTH-1:0] s1_new;
    logic              upd_drop_q;
    logic              upd_accept;

    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [CWIDTH-1:0] wr_data;

    assign ready      = (state_q == ST_RUN);
    assign upd_drop   = upd_drop_q;
    assign upd_accept = upd_valid & ready;

    bht_sat_ctr #(.CWIDTH(CWIDTH)) u_sat (
        .ctr_i   (s1_old_q),
        .taken_i (s1_taken_q),
        .ctr_o   (s1_new)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + AWIDTH'(1);
            if (ptr_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    // Single write port: the sweep owns it in INIT, stage 1 owns it in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_addr_q;
        wr_data = s1_new;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = ptr_q;
            wr_data = INIT_CTR;
        end else if (s1_valid_q) begin
            wr_en = 1'b1;
        end
    end

    always_comb begin
        s1_old_d = mem_q[upd_addr];
        if (wr_en && (wr_addr == upd_addr)) begin
            s1_old_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            upd_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= upd_accept;
            upd_drop_q <= upd_valid & ~ready;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr_q  <= upd_addr;
        s1_taken_q <= upd_taken;
        s1_old_q   <= s1_old_d;
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AWIDTH-1:0] ra;
        logic [CWIDTH-1:0] ctr_q, ctr_d;

        assign ra = rd_addr[gi*AWIDTH +: AWIDTH];

        always_comb begin
            ctr_d = mem_q[ra];
            if (!ready) begin
                ctr_d = INIT_CTR;
            end else if (wr_en && (wr_addr == ra)) begin
                ctr_d = wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                ctr_q <= INIT_CTR;
            end else begin
                ctr_q <= ctr_d;
            end
        end

        assign rd_ctr[gi*CWIDTH +: CWIDTH] = ctr_q;
        assign rd_taken[gi]                = ctr_q[CWIDTH-1];
    end

endmodule

// File: tb/tb_bht_sat_ctr_table.sv
// Directed and table-driven checks on a 16-entry 2-bit table, plus a 4-port
// 3-bit instance compared against an architectural model under random updates.
module tb_bht_sat_ctr_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1;
    logic [7:0] a_rd_addr = '0;
    logic [3:0] a_rd_ctr;
    logic [1:0] a_rd_taken;
    logic       a_upd_valid = 1'b0;
    logic [3:0] a_upd_addr = '0;
    logic       a_upd_taken = 1'b0;
    logic       a_ready, a_upd_drop;

    logic        b_reset = 1'b1;
    logic [15:0] b_rd_addr = '0;
    logic [11:0] b_rd_ctr;
    logic [3:0]  b_rd_taken;
    logic        b_upd_valid = 1'b0;
    logic [3:0]  b_upd_addr = '0;
    logic        b_upd_taken = 1'b0;
    logic        b_ready, b_upd_drop;

    bht_sat_ctr_table #(.AWIDTH(4), .CWIDTH(2), .NREAD(2), .INIT_VAL(1)) u_dut_a (
        .clk(clk), .reset(a_reset), .rd_addr(a_rd_addr), .rd_ctr(a_rd_ctr),
        .rd_taken(a_rd_taken), .upd_valid(a_upd_valid), .upd_addr(a_upd_addr),
        .upd_taken(a_upd_taken), .ready(a_ready), .upd_drop(a_upd_drop)
    );

    bht_sat_ctr_table #(.AWIDTH(4), .CWIDTH(3), .NREAD(4), .INIT_VAL(1)) u_dut_b (
        .clk(clk), .reset(b_reset), .rd_addr(b_rd_addr), .rd_ctr(b_rd_ctr),
        .rd_taken(b_rd_taken), .upd_valid(b_upd_valid), .upd_addr(b_upd_addr),
        .upd_taken(b_upd_taken), .ready(b_ready), .upd_drop(b_upd_drop)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int addr;
        int taken;
        int exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic a_upd(input int addr, input int taken);
        a_upd_valid = 1'b1;
        a_upd_addr  = 4'(addr);
        a_upd_taken = (taken != 0);
        tick();
        a_upd_valid = 1'b0;
    endtask

    task automatic a_read2(input int ad0, input int ad1, input int e0, input int e1,
                           input string nm);
        a_rd_addr = {4'(ad1), 4'(ad0)};
        tick();
        chk({nm, "_p0"}, int'(a_rd_ctr[1:0]), e0);
        chk({nm, "_p1"}, int'(a_rd_ctr[3:2]), e1);
        chk({nm, "_tk0"}, int'(a_rd_taken[0]), e0 >> 1);
        chk({nm, "_tk1"}, int'(a_rd_taken[1]), e1 >> 1);
    endtask

    task automatic a_wait_ready(output int n);
        n = 0;
        while (!a_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic int sat_m(input int c, input int t, input int mx);
        if (t != 0) return (c == mx) ? mx : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[10];
        int   n;
        int   refm[16];
        int   ra[4];
        int   ex[4];
        int   ph;

        vt[0] = '{5, 1, 2}; vt[1] = '{5, 1, 3}; vt[2] = '{5, 1, 3}; vt[3] = '{5, 1, 3};
        vt[4] = '{5, 0, 2}; vt[5] = '{5, 0, 1}; vt[6] = '{5, 0, 0}; vt[7] = '{5, 0, 0};
        vt[8] = '{0, 1, 2}; vt[9] = '{15, 0, 0};

        // Reset values and init sweep with a dropped update on the first cycle.
        tick(); tick();
        chk("rst_ready", int'(a_ready), 0);
        chk("rst_drop", int'(a_upd_drop), 0);
        chk("rst_ctr", int'(a_rd_ctr), 4'b0101);
        chk("rst_taken", int'(a_rd_taken), 0);
        a_reset     = 1'b0;
        a_upd_valid = 1'b1;
        a_upd_addr  = 4'd7;
        a_upd_taken = 1'b1;
        tick();
        n = 1;
        a_upd_valid = 1'b0;
        chk("init_drop", int'(a_upd_drop), 1);
        chk("init_ready_low", int'(a_ready), 0);
        chk("init_ctr_p0", int'(a_rd_ctr[1:0]), 1);
        while (!a_ready && n < 100) begin
            tick();
            n++;
        end
        chk("init_edges", n, 16);
        chk("drop_one_pulse", int'(a_upd_drop), 0);

        // Update in the first ready cycle is accepted.
        a_upd(12, 1);
        chk("ready_upd_drop", int'(a_upd_drop), 0);
        for (int i = 0; i < 16; i++) begin
            a_read2(i, 15 - i, (i == 12) ? 2 : 1, (15 - i == 12) ? 2 : 1,
                    $sformatf("sweep%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            a_upd(vt[i].addr, vt[i].taken);
            tick();
            a_read2(vt[i].addr, vt[i].addr, vt[i].exp, vt[i].exp, $sformatf("sat%0d", i));
        end

        // Back-to-back forwarding.
        a_upd(9, 1); a_upd(9, 1); a_upd(9, 0);
        tick();
        a_read2(9, 9, 2, 2, "b2b_9");
        a_upd(9, 1); a_upd(9, 1); a_upd(9, 1); a_upd(10, 1);
        tick();
        a_read2(9, 10, 3, 2, "b2b_9_10");

        // Write-first bypass: the read edge is the edge stage 1 writes index 9.
        a_upd(9, 0); a_upd(9, 0);
        tick();
        a_read2(9, 9, 1, 1, "byp_pre");
        a_upd(9, 1);
        a_read2(9, 9, 2, 2, "byp_same_edge");
        a_read2(9, 9, 2, 2, "byp_after");

        // Reset one cycle after an update is issued.
        a_upd(3, 1); a_upd(3, 1);
        tick();
        a_read2(3, 3, 3, 3, "mid_pre");
        a_upd(3, 0);
        a_reset = 1'b1;
        tick();
        chk("mid_ready", int'(a_ready), 0);
        chk("mid_ctr", int'(a_rd_ctr), 4'b0101);
        a_reset = 1'b0;
        a_wait_ready(n);
        chk("mid_edges", n, 16);
        a_read2(3, 5, 1, 1, "mid_post");

        // Parametric instance against an architectural model.
        tick(); tick();
        b_reset = 1'b0;
        n = 0;
        while (!b_ready && n < 100) begin
            tick();
            n++;
        end
        chk("b_init_edges", n, 16);
        for (int i = 0; i < 16; i++) refm[i] = 1;
        for (int c = 0; c < 400; c++) begin
            ph = (c / 40) % 2;
            b_upd_valid = ($urandom_range(0, 4) != 0);
            b_upd_addr  = 4'($urandom_range(0, 3));
            b_upd_taken = ($urandom_range(0, 9) < ((ph == 0) ? 8 : 2));
            n = $urandom_range(0, 15);
            for (int k = 0; k < 4; k++) begin
                ra[k] = (n + k) % 16;
                b_rd_addr[k*4 +: 4] = 4'(ra[k]);
                ex[k] = refm[ra[k]];
            end
            if (b_upd_valid) refm[b_upd_addr] = sat_m(refm[b_upd_addr], int'(b_upd_taken), 7);
            tick();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b_c%0d_p%0d_ctr", c, k), int'(b_rd_ctr[k*3 +: 3]), ex[k]);
                chk($sformatf("b_c%0d_p%0d_tk", c, k), int'(b_rd_taken[k]), ex[k] >> 2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
